// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared GEMM constants, BRAM2 geometry and drain FSM states
package gemm_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PE_SIZE    = 14;
  localparam int OUT_CH     = 64;

  localparam int MEM2_DEPTH      = PE_SIZE * OUT_CH;
  localparam int MEM2_DATA_WIDTH = PE_SIZE * DATA_WIDTH;
  localparam int MEM2_ADDR_WIDTH = $clog2(MEM2_DEPTH);

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_RUN   = 2'd1,
    DRAIN_FLUSH = 2'd2,
    DRAIN_DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/drain_skid_fifo.sv
// rtl/drain_skid_fifo.sv - 2-entry skid FIFO with registered head output
module drain_skid_fifo #(
  parameter int WIDTH = 112
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             pop;
  logic             push;

  // Next-state for the two slots; the head slot is always the oldest entry.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop     = pop_i && (count_q != 2'd0);
    push    = push_i && ((count_q != 2'd2) || pop);
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data_i;
        else                 tail_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/actmap_drain.sv
// rtl/actmap_drain.sv - BRAM2 activation-map drain to valid/ready stream (ACTMAP_DRAIN_RELU_EN clamps negative lanes)
module actmap_drain
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = gemm_pkg::DATA_WIDTH,
  parameter int PE_SIZE    = gemm_pkg::PE_SIZE,
  parameter int OUT_CH     = gemm_pkg::OUT_CH,
  localparam int MEM_DEPTH      = PE_SIZE * OUT_CH,
  localparam int MEM_DATA_WIDTH = PE_SIZE * DATA_WIDTH,
  localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      drain_start_i,
  output logic                      drain_busy_o,
  output logic                      drain_done_o,
  output logic                      mem_ce0_o,
  output logic                      mem_we0_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr0_o,
  input  logic [MEM_DATA_WIDTH-1:0] mem_q0_i,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [MEM_DATA_WIDTH-1:0] m_data_o,
  output logic                      m_last_o
);

  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ONE       = MEM_ADDR_WIDTH'(1);

  drain_state_e              state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_ADDR_WIDTH-1:0] beat_q, beat_d;
  logic                      inflight_q, inflight_d;
  logic [1:0]                fifo_count;
  logic [MEM_DATA_WIDTH-1:0] fifo_head;
  logic [MEM_DATA_WIDTH-1:0] push_data;
  logic                      fifo_valid;
  logic                      pop;
  logic                      issue;
  logic [2:0]                credit_used;

  assign fifo_valid  = (fifo_count != 2'd0);
  assign pop         = fifo_valid && m_ready_i;
  // Slots already spoken for after this cycle's pop; a read is only issued
  // when the landing word is guaranteed a free slot.
  assign credit_used = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign issue       = (state_q == DRAIN_RUN) && (credit_used < 3'd2);

`ifdef ACTMAP_DRAIN_RELU_EN
  // Clamp signed-negative lanes to zero before they enter the FIFO.
  always_comb begin
    push_data = mem_q0_i;
    for (int i = 0; i < PE_SIZE; i++) begin
      if (mem_q0_i[i*DATA_WIDTH + DATA_WIDTH - 1]) push_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end
`else
  assign push_data = mem_q0_i;
`endif

  drain_skid_fifo #(
    .WIDTH (MEM_DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  // Drain sequencing: address walk, beat counting and FSM transitions.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    inflight_d = issue;
    if (pop) beat_d = beat_q + ONE;
    case (state_q)
      DRAIN_IDLE: begin
        if (drain_start_i) begin
          state_d = DRAIN_RUN;
          addr_d  = '0;
          beat_d  = '0;
        end
      end
      DRAIN_RUN: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) state_d = DRAIN_FLUSH;
          else                     addr_d  = addr_q + ONE;
        end
      end
      DRAIN_FLUSH: begin
        if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)))
          state_d = DRAIN_DONE;
      end
      DRAIN_DONE: state_d = DRAIN_IDLE;
      default:    state_d = DRAIN_IDLE;
    endcase
  end

  // Control registers; reset discards any drain in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DRAIN_IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
    end
  end

  assign drain_busy_o = (state_q == DRAIN_RUN) || (state_q == DRAIN_FLUSH);
  assign drain_done_o = (state_q == DRAIN_DONE);
  assign mem_ce0_o    = issue;
  assign mem_we0_o    = 1'b0;
  assign mem_addr0_o  = addr_q;
  assign m_valid_o    = fifo_valid;
  assign m_data_o     = fifo_head;
  assign m_last_o     = fifo_valid && (beat_q == LAST_ADDR);

endmodule

// File: tb/tb_actmap_drain.sv
// tb/tb_actmap_drain.sv - scoreboard bench for actmap_drain
module tb_actmap_drain;

  localparam int DW    = 8;
  localparam int PE    = 14;
  localparam int OC    = 64;
  localparam int DEPTH = PE * OC;
  localparam int MW    = PE * DW;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          drain_start = 1'b0;
  logic          ready = 1'b0;
  logic          busy, done, ce, we, valid, last;
  logic [AW-1:0] addr;
  logic [MW-1:0] q = '0;
  logic [MW-1:0] data;

  logic [MW-1:0] mem [DEPTH];

  typedef struct {
    logic [MW-1:0] data;
    bit            last;
  } beat_t;
  beat_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0       = 0;
  int first_valid = -1;
  int done_cyc = -1;
  int done_cnt = 0;
  int ce_cnt   = 0;
  int accepted = 0;
  int last_cnt = 0;
  int outstanding = 0;
  bit prev_stall = 1'b0;
  logic [MW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  actmap_drain dut (
    .clk           (clk),
    .rst           (rst),
    .drain_start_i (drain_start),
    .drain_busy_o  (busy),
    .drain_done_o  (done),
    .mem_ce0_o     (ce),
    .mem_we0_o     (we),
    .mem_addr0_o   (addr),
    .mem_q0_i      (q),
    .m_valid_o     (valid),
    .m_ready_i     (ready),
    .m_data_o      (data),
    .m_last_o      (last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (ce) q <= mem[addr];

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] in_lane(input int pat, input int k, input int j);
    if (pat == 0) return k[7:0];
    case ((k + j) % 4)
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'hFF;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] exp_lane(input int pat, input int k, input int j);
`ifdef ACTMAP_DRAIN_RELU_EN
    if (pat == 0) return k[7] ? 8'h00 : k[7:0];
    case ((k + j) % 4)
      0:       return 8'h00;
      1:       return 8'h7F;
      2:       return 8'h00;
      default: return 8'h01;
    endcase
`else
    return in_lane(pat, k, j);
`endif
  endfunction

  task automatic preload(input int pat);
    for (int k = 0; k < DEPTH; k++)
      for (int j = 0; j < PE; j++)
        mem[k][j*DW +: DW] = in_lane(pat, k, j);
  endtask

  task automatic push_expected(input int pat);
    beat_t b;
    for (int k = 0; k < DEPTH; k++) begin
      for (int j = 0; j < PE; j++) b.data[j*DW +: DW] = exp_lane(pat, k, j);
      b.last = (k == DEPTH - 1);
      sb.push_back(b);
    end
  endtask

  task automatic clear_stats();
    accepted = 0; last_cnt = 0; done_cnt = 0; ce_cnt = 0;
    first_valid = -1; done_cyc = -1;
  endtask

  task automatic start_drain();
    @(posedge clk); #1;
    check_eq("busy_idle", busy, 1'b0);
    drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    t0 = cyc;
    check_eq("busy_run", busy, 1'b1);
    check_eq("first_ce", ce, 1'b1);
    check_eq("first_addr", addr, 0);
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(posedge clk); #1;
      if (toggle) ready = ~ready;
      i++;
    end
    check_eq("done_seen", done_cnt != d0, 1'b1);
    ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic wait_accepted(input int n, input int budget);
    int i = 0;
    while (accepted < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    check_eq("reach_beat", accepted >= n, 1'b1);
  endtask

  // Monitor: samples on the falling edge what the next rising edge will see.
  always @(negedge clk) begin
    beat_t e;
    bit    pop_now;
    if (rst) begin
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      pop_now = valid && ready;
      check_eq("we_tied_low", we, 1'b0);
      if (prev_stall) begin
        check_eq("stall_valid", valid, 1'b1);
        check_eq("stall_data", data, prev_data);
        check_eq("stall_last", last, prev_last);
      end
      if (ce) begin
        ce_cnt++;
        check_eq("credit", (outstanding - int'(pop_now)) < 2, 1'b1);
      end
      if (valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("done_sb_empty", sb.size(), 0);
      end
      if (pop_now) begin
        if (sb.size() == 0) begin
          check_eq("extra_beat", data, '1);
        end else begin
          e = sb.pop_front();
          check_eq("beat_data", data, e.data);
          check_eq("beat_last", last, e.last);
        end
        accepted++;
        if (last) last_cnt++;
      end
      outstanding = outstanding + int'(ce) - int'(pop_now);
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_last  = last;
    end
  end

  initial begin
    preload(0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_ce", ce, 1'b0);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_busy_done_last", {busy, done, last}, 3'b000);
    rst = 1'b0;

    // Continuous ready: latency, throughput, last marker, done timing.
    ready = 1'b1;
    clear_stats();
    push_expected(0);
    start_drain();
    wait_done(2000, 1'b0);
    check_eq("first_valid_cycle", first_valid - t0 + 1, 3);
    check_eq("done_cycle", done_cyc - t0 + 1, 899);
    check_eq("beats_a", accepted, DEPTH);
    check_eq("last_once_a", last_cnt, 1);
    check_eq("reads_a", ce_cnt, DEPTH);
    check_eq("done_once_a", done_cnt, 1);
    check_eq("busy_after_a", busy, 1'b0);

    // Ready toggling every cycle.
    clear_stats();
    push_expected(0);
    start_drain();
    wait_done(4000, 1'b1);
    check_eq("beats_b", accepted, DEPTH);
    check_eq("last_once_b", last_cnt, 1);
    check_eq("done_once_b", done_cnt, 1);

    // Sink stalled for 20 cycles right after start.
    ready = 1'b0;
    clear_stats();
    push_expected(0);
    start_drain();
    repeat (20) @(posedge clk);
    #1;
    check_eq("stall_reads", ce_cnt, 2);
    check_eq("stall_beats", accepted, 0);
    ready = 1'b1;
    wait_done(2000, 1'b0);
    check_eq("beats_c", accepted, DEPTH);

    // Second start mid-drain is ignored.
    clear_stats();
    push_expected(0);
    start_drain();
    wait_accepted(100, 500);
    #1 drain_start = 1'b1;
    @(posedge clk); #1 drain_start = 1'b0;
    wait_done(2000, 1'b0);
    check_eq("beats_d", accepted, DEPTH);
    check_eq("done_once_d", done_cnt, 1);
    check_eq("sb_empty_d", sb.size(), 0);

    // Reset mid-drain, then a fresh drain from address 0.
    clear_stats();
    push_expected(0);
    start_drain();
    wait_accepted(300, 1000);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check_eq("abort_outputs", {busy, done, ce, valid, last}, 5'b0);
    check_eq("abort_addr", addr, 0);
    check_eq("abort_data", data, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_no_done", done_cnt, 0);
    clear_stats();
    push_expected(0);
    start_drain();
    wait_done(2000, 1'b0);
    check_eq("beats_e", accepted, DEPTH);
    check_eq("done_once_e", done_cnt, 1);

    // Mixed-sign lane pattern.
    preload(1);
    clear_stats();
    push_expected(1);
    start_drain();
    wait_done(2000, 1'b0);
    check_eq("beats_f", accepted, DEPTH);
    check_eq("sb_empty_f", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/actmap_drain.md
Name: actmap_drain

Overview:
- Reads the activation-map BRAM (BRAM2) after GEMM completes and streams its contents to the outside world over a valid/ready interface.
- Owns BRAM2 port 0 during a drain. It is the read-side counterpart of the GEMM write path into BRAM2.
- Absorbs the 1-cycle BRAM read latency with a 2-entry skid FIFO.
- Sustains 1 beat/cycle under continuous ready and never drops a beat under backpressure.

Parameters:
- DATA_WIDTH, 8, activation element width.
- PE_SIZE, 14, elements per BRAM word.
- OUT_CH, 64, output channels.
- MEM_DEPTH, PE_SIZE*OUT_CH (896), words to drain (localparam-derived).
- MEM_DATA_WIDTH, PE_SIZE*DATA_WIDTH (112), BRAM word width (localparam).
- MEM_ADDR_WIDTH, $clog2(MEM_DEPTH) (10), BRAM address width (localparam).

Ports:
- clk  in  1  single clock.
- rst  in  1  reset: synchronous, active-high.
- drain_start_i  in  1  pulse that starts a drain; sampled only in IDLE.
- drain_busy_o  out  1  high from the cycle after start is accepted until DONE.
- drain_done_o  out  1  one-cycle pulse after the last beat is accepted.
- mem_ce0_o  out  1  BRAM2 port-0 chip enable (read strobe).
- mem_we0_o  out  1  BRAM2 port-0 write enable; tied 0.
- mem_addr0_o  out  MEM_ADDR_WIDTH  BRAM2 port-0 address.
- mem_q0_i  in  MEM_DATA_WIDTH  BRAM2 read data, valid 1 cycle after ce.
- m_valid_o  out  1  stream data valid.
- m_ready_i  in  1  stream sink ready.
- m_data_o  out  MEM_DATA_WIDTH  stream beat, one BRAM word.
- m_last_o  out  1  high with the beat from address MEM_DEPTH-1.

Behaviour:
- Reset values: all outputs 0. FSM=IDLE. Address counter 0, in-flight flag 0, FIFO empty, beat counter 0.
- Reset mid-drain aborts immediately: no drain_done_o, FIFO contents discarded.
- FSM states:
  - IDLE: drain_start_i=1 → RUN; address counter cleared. drain_start_i in any other state is ignored.
  - RUN: issues reads addr 0..MEM_DEPTH-1 in ascending order. After addr MEM_DEPTH-1 is issued → FLUSH.
  - FLUSH: waits until the in-flight read has landed, the FIFO is empty and the final handshake is done → DONE.
  - DONE: drain_done_o=1 for this cycle → IDLE.
- Read issue (RUN): mem_ce0_o=1 when (fifo_count + inflight − pop_this_cycle) < 2. The address increments on each issue. mem_addr0_o holds its value when no read is issued.
- Read return: the cycle after mem_ce0_o=1, mem_q0_i is pushed into the FIFO. The FIFO is never full at push, guaranteed by the credit rule.
- Stream:
  - m_valid_o = FIFO non-empty; m_data_o = FIFO head, registered.
  - Handshake on m_valid_o & m_ready_i pops the head.
  - While m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o hold stable.
  - m_valid_o never deasserts without a handshake.
- Latency: start sampled at edge N → mem_ce0_o (addr 0) in cycle N+1 → m_valid_o first high in cycle N+3.
- Throughput: 1 beat/cycle with m_ready_i=1.
- m_last_o: the beat counter reaches MEM_DEPTH-1 at the head.
- Simultaneous push and pop with the FIFO at count 1 → count stays 1, order preserved.
- Address counter stops at MEM_DEPTH-1; no wrap or overrun reads.

Optional Feature:
- ACTMAP_DRAIN_RELU_EN defined: each DATA_WIDTH lane of m_data_o is treated as signed; lanes with MSB=1 output 0. This is applied at FIFO push, and timing is unchanged.
- Undefined: data passes through bit-exact.

Decomposition:
- Shared package gemm_pkg:
  - DATA_WIDTH/PE_SIZE/OUT_CH defaults.
  - MEM2 depth/width/address-width constants.
  - drain FSM state enum (IDLE, RUN, FLUSH, DONE).
- Sub-module drain_skid_fifo: 2-entry, registered-output FIFO with push, pop, count and head.

Test Plan:
- BRAM2 preloaded with word k = {PE_SIZE{k[7:0]}}, start at cycle 0, m_ready_i=1 → 896 beats in order, first m_valid_o at cycle 3, m_last_o on beat 895 only, drain_done_o pulse at cycle 899.
- Same preload, m_ready_i toggling 1/0 every cycle → all 896 words in order, no duplicates, data stable while stalled, mem_ce0_o never issued with 2 words buffered.
- m_ready_i=0 for 20 cycles after start → exactly 2 reads issued then ce held 0; release → beats 0,1,2… contiguous.
- drain_start_i pulsed again at beat 100 → ignored; beat count still 896, single drain_done_o.
- rst=1 at beat 300 → next cycle all outputs 0, no done; new start → drain restarts from addr 0.
- ACTMAP_DRAIN_RELU_EN defined, word lanes 0x80,0x7F,0xFF,0x01 → output lanes 0x00,0x7F,0x00,0x01.
